// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file write-back arbiter.
// Requester indices, slot payload layout, pending-counter type.
package regfile_wb_arbiter_pkg;

  localparam int REGISTER_DATA_BITS = 8;
  localparam int NUM_REGS = 16;

  localparam int WB_REQ_ALU = 0;
  localparam int WB_REQ_MEM = 1;

  typedef struct packed {
    logic [3:0]                    addr;
    logic [REGISTER_DATA_BITS-1:0] data;
  } wb_req_t;

  typedef logic [1:0] pend_cnt_t;

endpackage

// File: rtl/wb_holding_slot.sv
// One-entry write-back holding slot: valid, age bit and payload.
// Load wins over drain; drain wins over age clear.
module wb_holding_slot
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_BITS = REGISTER_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 load,
  input  logic                 drain,
  input  logic                 age_clr,
  input  logic                 age_in,
  input  logic [3:0]           addr_in,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 valid,
  output logic                 age,
  output logic [3:0]           addr,
  output logic [DATA_BITS-1:0] data
);

  // Slot state: refill takes priority so a granted slot can reload at once.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid <= 1'b0;
      age   <= 1'b0;
      addr  <= '0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      age   <= age_in;
      addr  <= addr_in;
      data  <= data_in;
    end else if (drain) begin
      valid <= 1'b0;
      age   <= 1'b0;
    end else if (age_clr) begin
      age   <= 1'b0;
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and MEM write-back.
// Oldest-first arbitration, round-robin on ties, per-register pending mask.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DATA_BITS = REGISTER_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 alu_valid,
  input  logic [3:0]           alu_addr,
  input  logic [DATA_BITS-1:0] alu_data,
  output logic                 alu_ready,
  input  logic                 mem_valid,
  input  logic [3:0]           mem_addr,
  input  logic [DATA_BITS-1:0] mem_data,
  output logic                 mem_ready,
  output logic [3:0]           wr_addr,
  output logic                 wr_enable,
  output logic [DATA_BITS-1:0] wr_data,
  output logic [15:0]          pending_mask,
  output logic                 idle
);

  logic [1:0] req_valid;
  logic [1:0] ready;
  logic [1:0] acc;
  logic [1:0] gnt;
  logic [1:0] busy_nxt;
  logic [1:0] s_valid;
  logic [1:0] s_age;
  logic       tie;
  logic       rr_ptr;

  logic [1:0][3:0]           s_addr;
  logic [1:0][DATA_BITS-1:0] s_data;

  assign req_valid[WB_REQ_ALU] = alu_valid;
  assign req_valid[WB_REQ_MEM] = mem_valid;

  // Grant: lone slot wins, else older slot, else rr_ptr breaks the tie.
  always_comb begin
    gnt = 2'b00;
    tie = 1'b0;
    unique case (s_valid)
      2'b01: gnt = 2'b01;
      2'b10: gnt = 2'b10;
      2'b11: begin
        if (s_age[0] != s_age[1]) begin
          gnt = s_age[0] ? 2'b10 : 2'b01;
        end else begin
          tie = 1'b1;
          gnt = rr_ptr ? 2'b10 : 2'b01;
        end
      end
      default: gnt = 2'b00;
    endcase
  end

  assign ready    = ~s_valid | gnt;
  assign acc      = req_valid & ready;
  assign busy_nxt = acc | (s_valid & ~gnt);

  assign alu_ready = ready[WB_REQ_ALU];
  assign mem_ready = ready[WB_REQ_MEM];

  wb_holding_slot #(
    .DATA_BITS(DATA_BITS)
  ) u_slot_alu (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (acc[WB_REQ_ALU]),
    .drain   (gnt[WB_REQ_ALU]),
    .age_clr (gnt[WB_REQ_MEM]),
    .age_in  (busy_nxt[WB_REQ_MEM]),
    .addr_in (alu_addr),
    .data_in (alu_data),
    .valid   (s_valid[WB_REQ_ALU]),
    .age     (s_age[WB_REQ_ALU]),
    .addr    (s_addr[WB_REQ_ALU]),
    .data    (s_data[WB_REQ_ALU])
  );

  wb_holding_slot #(
    .DATA_BITS(DATA_BITS)
  ) u_slot_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (acc[WB_REQ_MEM]),
    .drain   (gnt[WB_REQ_MEM]),
    .age_clr (gnt[WB_REQ_ALU]),
    .age_in  (busy_nxt[WB_REQ_ALU]),
    .addr_in (mem_addr),
    .data_in (mem_data),
    .valid   (s_valid[WB_REQ_MEM]),
    .age     (s_age[WB_REQ_MEM]),
    .addr    (s_addr[WB_REQ_MEM]),
    .data    (s_data[WB_REQ_MEM])
  );

  // Write-port register stage and tie pointer.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_enable <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
      rr_ptr    <= 1'b0;
    end else begin
      wr_enable <= |gnt;
      if (gnt[WB_REQ_ALU]) begin
        wr_addr <= s_addr[WB_REQ_ALU];
        wr_data <= s_data[WB_REQ_ALU];
      end else if (gnt[WB_REQ_MEM]) begin
        wr_addr <= s_addr[WB_REQ_MEM];
        wr_data <= s_data[WB_REQ_MEM];
      end
      if (tie) begin
        rr_ptr <= ~rr_ptr;
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_pend
    pend_cnt_t cnt;
    pend_cnt_t inc_a;
    pend_cnt_t inc_m;
    pend_cnt_t dec;

    assign inc_a = {1'b0, acc[WB_REQ_ALU] && (alu_addr == 4'(i))};
    assign inc_m = {1'b0, acc[WB_REQ_MEM] && (mem_addr == 4'(i))};
    assign dec   = {1'b0, wr_enable && (wr_addr == 4'(i))};

    // Outstanding writes to this register: accepts minus commits.
    always_ff @(posedge clk) begin
      if (!reset_n) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + inc_a + inc_m - dec;
      end
    end

    assign pending_mask[i] = |cnt;
  end

  assign idle = !s_valid[WB_REQ_ALU] && !s_valid[WB_REQ_MEM] && !wr_enable;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed bench for regfile_wb_arbiter with a register-file model.
// Hand-computed expectations for each scenario.
module tb_regfile_wb_arbiter;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       alu_valid;
  logic [3:0] alu_addr;
  logic [7:0] alu_data;
  logic       alu_ready;
  logic       mem_valid;
  logic [3:0] mem_addr;
  logic [7:0] mem_data;
  logic       mem_ready;
  logic [3:0] wr_addr;
  logic       wr_enable;
  logic [7:0] wr_data;
  logic [15:0] pending_mask;
  logic       idle;

  logic [7:0] rf [16];
  logic       rf_live = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;
  int pulses;

  regfile_wb_arbiter #(.DATA_BITS(8)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .alu_valid    (alu_valid),
    .alu_addr     (alu_addr),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .mem_valid    (mem_valid),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .wr_addr      (wr_addr),
    .wr_enable    (wr_enable),
    .wr_data      (wr_data),
    .pending_mask (pending_mask),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rf_live) begin
      for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
    end else if (wr_enable) begin
      rf[wr_addr] <= wr_data;
    end
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n   = 1'b0;
    alu_valid = 1'b0;
    alu_addr  = '0;
    alu_data  = '0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_data  = '0;

    // reset then idle
    step();
    step();
    reset_n = 1'b1;
    rf_live = 1'b1;
    chk("rst_wr_en", wr_enable, 0);
    chk("rst_mask", pending_mask, 16'h0000);
    chk("rst_alu_rdy", alu_ready, 1);
    chk("rst_mem_rdy", mem_ready, 1);
    chk("rst_idle", idle, 1);

    // single ALU write
    alu_valid = 1'b1; alu_addr = 4'd5; alu_data = 8'hA5;
    step();
    alu_valid = 1'b0;
    chk("s_mask5", pending_mask[5], 1);
    chk("s_wr_en0", wr_enable, 0);
    step();
    chk("s_wr_en1", wr_enable, 1);
    chk("s_wr_addr", wr_addr, 5);
    chk("s_wr_data", wr_data, 8'hA5);
    step();
    chk("s_r5", rf[5], 8'hA5);
    chk("s_mask_clr", pending_mask, 16'h0000);
    chk("s_idle", idle, 1);

    // tie pair 1: ALU first
    alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 8'h11;
    mem_valid = 1'b1; mem_addr = 4'd3; mem_data = 8'h22;
    step();
    alu_valid = 1'b0; mem_valid = 1'b0;
    chk("t1_mask3", pending_mask[3], 1);
    chk("t1_alu_rdy", alu_ready, 1);
    chk("t1_mem_rdy", mem_ready, 0);
    step();
    chk("t1_first", wr_data, 8'h11);
    step();
    chk("t1_second", wr_data, 8'h22);
    chk("t1_r3_mid", rf[3], 8'h11);
    chk("t1_mask3_mid", pending_mask[3], 1);
    step();
    chk("t1_r3", rf[3], 8'h22);
    chk("t1_mask", pending_mask, 16'h0000);

    // tie pair 2: MEM first after rr flip
    alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 8'h33;
    mem_valid = 1'b1; mem_addr = 4'd3; mem_data = 8'h44;
    step();
    alu_valid = 1'b0; mem_valid = 1'b0;
    chk("t2_alu_rdy", alu_ready, 0);
    chk("t2_mem_rdy", mem_ready, 1);
    step();
    chk("t2_first", wr_data, 8'h44);
    step();
    chk("t2_second", wr_data, 8'h33);
    chk("t2_mask3_mid", pending_mask[3], 1);
    step();
    chk("t2_r3", rf[3], 8'h33);
    chk("t2_mask", pending_mask, 16'h0000);

    // oldest-first: MEM one cycle ahead of ALU
    mem_valid = 1'b1; mem_addr = 4'd7; mem_data = 8'h01;
    step();
    mem_valid = 1'b0;
    alu_valid = 1'b1; alu_addr = 4'd7; alu_data = 8'h02;
    chk("o_mem_rdy", mem_ready, 1);
    step();
    alu_valid = 1'b0;
    chk("o_first_addr", wr_addr, 7);
    chk("o_first_data", wr_data, 8'h01);
    step();
    chk("o_second_data", wr_data, 8'h02);
    step();
    chk("o_r7", rf[7], 8'h02);
    chk("o_mask", pending_mask, 16'h0000);

    // back-to-back ALU streaming
    for (int i = 0; i < 8; i++) begin
      alu_valid = 1'b1;
      alu_addr  = 4'(i);
      alu_data  = 8'h10 + 8'(i);
      chk("b_alu_rdy", alu_ready, 1);
      step();
      if (i > 0) begin
        chk("b_wr_en", wr_enable, 1);
        chk("b_wr_data", wr_data, 8'h10 + 8'(i - 1));
      end
    end
    alu_valid = 1'b0;
    step();
    chk("b_last_en", wr_enable, 1);
    chk("b_last_data", wr_data, 8'h17);
    step();
    chk("b_done_en", wr_enable, 0);
    for (int i = 0; i < 8; i++) begin
      chk("b_rf", rf[i], 8'h10 + 8'(i));
    end
    chk("b_mask", pending_mask, 16'h0000);

    // reset with both slots full and a write in flight
    alu_valid = 1'b1; alu_addr = 4'd9;  alu_data = 8'h99;
    mem_valid = 1'b1; mem_addr = 4'd10; mem_data = 8'hAA;
    step();
    mem_valid = 1'b0;
    alu_addr = 4'd11; alu_data = 8'hBB;
    step();
    alu_valid = 1'b0;
    chk("r_wr_en", wr_enable, 1);
    chk("r_wr_addr", wr_addr, 9);
    chk("r_alu_rdy", alu_ready, 0);
    chk("r_mask", pending_mask, 16'h0E00);
    chk("r_idle", idle, 0);
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    chk("r_post_en", wr_enable, 0);
    chk("r_post_mask", pending_mask, 16'h0000);
    chk("r_post_idle", idle, 1);
    chk("r_post_rdy", alu_ready, 1);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (wr_enable) pulses++;
    end
    chk("r_no_pulse", pulses, 0);
    chk("r_r10", rf[10], 8'h00);
    chk("r_r11", rf[11], 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port between two write-back requesters: ALU (index 0) and MEM/load (index 1).
- Each requester has a one-entry holding slot with valid/ready handshake. Arbitration is oldest-first, with round-robin on ties.
- Drives registered wr_addr/wr_enable/wr_data straight into register_file.
- Exports a per-register pending-write mask so the decoder can stall on RAW hazards.

Parameters:
- DATA_BITS, REGISTER_DATA_BITS: width of write data; must match register_file.

Ports:
- clk  in  1  system clock, rising edge
- reset_n  in  1  synchronous, active-low reset
- alu_valid  in  1  ALU write-back request
- alu_addr  in  4  ALU destination register
- alu_data  in  DATA_BITS  ALU result
- alu_ready  out  1  ALU slot can accept this cycle
- mem_valid  in  1  MEM write-back request
- mem_addr  in  4  MEM destination register
- mem_data  in  DATA_BITS  load data
- mem_ready  out  1  MEM slot can accept this cycle
- wr_addr  out  4  to register_file wr_addr
- wr_enable  out  1  to register_file wr_enable
- wr_data  out  DATA_BITS  to register_file wr_data
- pending_mask  out  16  bit i = one or more accepted writes to Ri not yet committed
- idle  out  1  both slots empty and wr_enable low

Behaviour:
- Reset (reset_n=0 at a rising edge): slots empty, wr_enable=0, wr_addr=0, wr_data=0, all pending counters=0, rr_ptr=0 (ALU favoured on first tie), age bits cleared. Consequently pending_mask=0, idle=1, alu_ready=mem_ready=1 after reset. Reset mid-operation discards buffered and in-flight writes; no wr_enable pulse follows.
- Handshake: a transfer occurs at an edge where X_valid && X_ready. X_ready = !slot_X.valid || grant_X, combinational from state only, never from X_valid.
- Slot: holds {addr, data} plus an age bit.
  - Age bit = 1 when the slot was loaded while the other slot was already occupied (meaning this slot is younger).
  - Age bit is cleared when the other slot drains.
- Arbitration, combinational, each cycle:
  - Exactly one occupied slot: it is granted.
  - Both occupied with differing age: the older slot (age=0) is granted.
  - Both occupied with equal age (loaded at the same edge): the slot selected by rr_ptr is granted.
  - rr_ptr flips to the other requester after every tie-grant.
- Issue: at the edge where a slot is granted, its addr/data load into the wr_* registers, wr_enable<=1 for one cycle, and the slot empties unless refilled at the same edge. With no grant, wr_enable<=0 and wr_addr/wr_data hold.
- Latency: accept at edge E0, grant evaluated in cycle E0..E1, wr_enable high between E1 and E2, register_file commits at E2. Minimum 2 cycles request-to-commit. Throughput is 1 write/cycle sustained with a single requester.
- Drain-and-refill: a granted slot accepts a new request at the same edge (ready=1). The new entry's age is set against the other slot's post-edge state.
- Same-address ordering: commit order equals grant order. For a tie the later-granted value is final in the register.
- Pending counters: one 2-bit counter per register (max 3 outstanding: two slots plus the output stage).
  - Increment on accept to addr.
  - Decrement at any edge where wr_enable=1, for wr_addr.
  - Two accepts to the same addr at one edge: +2.
  - Simultaneous increment and decrement on the same addr: net count.
  - pending_mask[i] = (cnt[i] != 0).
  - Counter overflow is structurally impossible. Verification asserts cnt <= 3.
- idle = !slot_alu.valid && !slot_mem.valid && !wr_enable.

Decomposition:
- constants_pkg additions:
  - WB_REQ_ALU=0, WB_REQ_MEM=1
  - typedef wb_req_t struct {logic [3:0] addr; logic [REGISTER_DATA_BITS-1:0] data;}
  - typedef logic [1:0] pend_cnt_t
- One sub-module: wb_holding_slot (valid/age/payload register with load/drain/age-clear controls), instantiated twice.
- Pending counters live in a generate loop in the top.

Test Plan:
- Reset then idle: hold reset_n=0 two cycles, release -> wr_enable=0, pending_mask=16'h0000, alu_ready=mem_ready=1, idle=1.
- Single ALU write: alu_valid one cycle with addr=5, data=8'hA5 -> pending_mask[5]=1 next cycle. wr_enable=1, wr_addr=5, wr_data=A5 in cycle 2. register_file R5=A5 after next edge. pending_mask[5]=0 after that edge.
- Simultaneous tie + round-robin: ALU (3, 11) and MEM (3, 22) at the same edge, twice in sequence (ALU (3, 11) and MEM (3, 22), then ALU (3, 33) and MEM (3, 44)).
  - First pair: ALU issues first, then MEM; R3 ends 22.
  - Second pair: MEM issues first (rr_ptr flipped), then ALU; R3 ends 33.
  - pending count for R3 peaks at 2 and returns to 0.
- Oldest-first: MEM (7, 01) accepted one cycle before ALU (7, 02) -> MEM issues first, R7 final = 02; mem_ready low only while the MEM slot is held and not granted.
- Back-to-back streaming: alu_valid high 8 cycles, addr 0..7, data 10..17, MEM idle -> alu_ready stays 1, wr_enable high 8 consecutive cycles, R0..R7 = 10..17.
- Reset mid-flight: both slots full plus wr_enable high, assert reset_n=0 for one edge -> wr_enable=0, pending_mask=0, no further commits, target registers keep their pre-reset value.
